// File: rtl/usbh_rx_crc16_check_pkg.sv
// Shared USB host definitions: CRC16 seed, data-packet PIDs and the RX checker states.
package usbh_defs;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    CHECK
  } state_t;

endpackage

// File: rtl/usbh_rx_crc16_check_if.sv
// Byte-stream and status bundle between the SIE receive path and the CRC16 checker.
interface usbh_rx_crc16_check_if #(
  parameter int LEN_W = 11
);
  logic             start_i;
  logic             data_valid_i;
  logic [7:0]       data_i;
  logic             end_i;
  logic             out_valid_o;
  logic [7:0]       out_data_o;
  logic             done_o;
  logic             crc_ok_o;
  logic             short_o;
  logic             overflow_o;
  logic [LEN_W-1:0] len_o;
  logic             busy_o;

  modport master (
    output start_i, data_valid_i, data_i, end_i,
    input  out_valid_o, out_data_o, done_o, crc_ok_o, short_o, overflow_o, len_o, busy_o
  );

  modport slave (
    input  start_i, data_valid_i, data_i, end_i,
    output out_valid_o, out_data_o, done_o, crc_ok_o, short_o, overflow_o, len_o, busy_o
  );
endinterface

// File: rtl/usbh_rx_crc16_check_crc.sv
// USB CRC16 single-byte update (x^16+x^15+x^2+1, reflected), data consumed LSB first.
module UsbCrc16 (
  input  logic [15:0] io_crc_i,
  input  logic [7:0]  io_data_i,
  output logic [15:0] io_crc_o
);
  logic [15:0] c;
  logic        fb;

  always_comb begin
    c  = io_crc_i;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ io_data_i[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'hA001;
    end
    io_crc_o = c;
  end
endmodule

// File: rtl/usbh_rx_crc16_check.sv
// RX DATA-packet checker: strips the trailing CRC16 via a 2-byte hold buffer, forwards
// payload bytes and reports CRC/short/overflow status plus payload length at end of packet.
module usbh_rx_crc16_check
  import usbh_defs::*;
#(
  parameter int MAX_LEN = 1023,
  parameter int LEN_W   = 11
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  usbh_rx_crc16_check_if.slave bus
);

  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [15:0]      crc_q, crc_next;
  logic [7:0]       hold0_q, hold1_q;
  logic [1:0]       hcnt_q;
  logic [LEN_W-1:0] nbytes_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             accept, in_check, short_pkt;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (v >= LEN_SAT) ? LEN_SAT : v + 1'b1;
  endfunction

  UsbCrc16 u_crc (
    .io_crc_i  (crc_q),
    .io_data_i (hold0_q),
    .io_crc_o  (crc_next)
  );

  // A restart wins over any byte arriving in the same cycle.
  assign accept = (state_q == ACTIVE) && bus.data_valid_i && !bus.start_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = ACTIVE;
      ACTIVE:  if (!bus.start_i && bus.end_i) state_d = CHECK;
      CHECK:   state_d = bus.start_i ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Stage p0 -> p1: hold buffer shift; the evicted older byte becomes registered payload output.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      crc_q       <= CRC16_INIT;
      hcnt_q      <= 2'd0;
      nbytes_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.start_i) begin
        crc_q    <= CRC16_INIT;
        hcnt_q   <= 2'd0;
        nbytes_q <= '0;
      end else if (accept) begin
        if (hcnt_q == 2'd2) begin
          out_valid_q <= 1'b1;
          out_data_q  <= hold0_q;
          crc_q       <= crc_next;
          nbytes_q    <= sat_inc(nbytes_q);
        end else begin
          hcnt_q <= hcnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      hold1_q <= bus.data_i;
      hold0_q <= hold1_q;
    end
  end

  // Status is read straight from the settled registers during the single CHECK cycle.
  assign in_check  = (state_q == CHECK) && !bus.start_i;
  assign short_pkt = (hcnt_q != 2'd2);

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.done_o      = in_check;
  assign bus.short_o     = in_check && short_pkt;
  assign bus.crc_ok_o    = in_check && !short_pkt && ({hold1_q, hold0_q} == ~crc_q);
  assign bus.overflow_o  = in_check && (nbytes_q > LEN_MAX);
  assign bus.len_o       = (state_q == ACTIVE) ? '0 : nbytes_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_usbh_rx_crc16_check.sv
// Randomized scoreboard bench for usbh_rx_crc16_check with a table-driven CRC16 reference.
module tb_usbh_rx_crc16_check;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 11;

  typedef struct packed {
    logic             crc_ok;
    logic             short_p;
    logic             ovf;
    logic [LEN_W-1:0] len;
  } status_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  usbh_rx_crc16_check_if #(.LEN_W(LEN_W)) bus();

  usbh_rx_crc16_check #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  logic [7:0]  exp_out[$];
  status_t     exp_st[$];
  logic [7:0]  pkt[$];
  logic [15:0] crc_tab[256];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.out_valid_o) begin
      if (exp_out.size() == 0) check("unexpected_out", {24'h0, bus.out_data_o}, 32'hFFFF_FFFF);
      else                     check("out_data", {24'h0, bus.out_data_o}, {24'h0, exp_out.pop_front()});
    end
    if (bus.done_o) begin
      if (exp_st.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        status_t s;
        s = exp_st.pop_front();
        check("crc_ok",   32'(bus.crc_ok_o),   32'(s.crc_ok));
        check("short",    32'(bus.short_o),    32'(s.short_p));
        check("overflow", 32'(bus.overflow_o), 32'(s.ovf));
        check("len",      32'(bus.len_o),      32'(s.len));
      end
    end
  end

  function automatic logic [15:0] model_crc(input int p);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < p; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ pkt[i]];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.data_i = 8'($urandom);
      tick();
    end
  endtask

  task automatic start_pkt();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    @(negedge clk);
    check("busy_active", 32'(bus.busy_o), 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input bit with_end);
    bus.data_valid_i = 1'b1;
    bus.data_i       = b;
    bus.end_i        = with_end;
    tick();
    bus.data_valid_i = 1'b0;
    bus.end_i        = 1'b0;
  endtask

  task automatic check_all_zero();
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_out_data",  32'(bus.out_data_o),  32'd0);
    check("rst_done",      32'(bus.done_o),      32'd0);
    check("rst_crc_ok",    32'(bus.crc_ok_o),    32'd0);
    check("rst_short",     32'(bus.short_o),     32'd0);
    check("rst_overflow",  32'(bus.overflow_o),  32'd0);
    check("rst_len",       32'(bus.len_o),       32'd0);
    check("rst_busy",      32'(bus.busy_o),      32'd0);
  endtask

  task automatic run_pkt(input bit use_model, input status_t st_in, input bit end_last, input int maxgap);
    status_t st;
    int n, p;
    logic [15:0] c;
    logic [7:0] lo, hi;
    n = pkt.size();
    for (int i = 0; i < n - 2; i++) exp_out.push_back(pkt[i]);
    if (use_model) begin
      p  = (n < 2) ? 0 : n - 2;
      c  = model_crc(p);
      lo = ~c[7:0];
      hi = ~c[15:8];
      st.short_p = (n < 2);
      st.crc_ok  = (n >= 2) && (pkt[n-2] == lo) && (pkt[n-1] == hi);
      st.ovf     = (p > MAX_LEN);
      st.len     = LEN_W'((p > MAX_LEN + 1) ? MAX_LEN + 1 : p);
    end else begin
      st = st_in;
    end
    exp_st.push_back(st);
    start_pkt();
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, maxgap));
      send(pkt[i], end_last && (i == n - 1));
    end
    if (!(end_last && n > 0)) begin
      bus.end_i = 1'b1;
      tick();
      bus.end_i = 1'b0;
    end
    @(negedge clk);
    check("done_latency", 32'(bus.done_o), 32'd1);
    tick();
    tick();
    @(negedge clk);
    check("busy_after", 32'(bus.busy_o), 32'd0);
    check("len_held",   32'(bus.len_o),  32'(st.len));
  endtask

  function automatic status_t mk(input logic ok, input logic sh, input logic ov, input int len);
    status_t s;
    s.crc_ok  = ok;
    s.short_p = sh;
    s.ovf     = ov;
    s.len     = LEN_W'(len);
    return s;
  endfunction

  initial begin
    logic [15:0] c;
    int p, idx;
    for (int i = 0; i < 256; i++) begin
      c = 16'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      crc_tab[i] = c;
    end
    bus.start_i = 1'b0; bus.data_valid_i = 1'b0; bus.data_i = 8'h00; bus.end_i = 1'b0;

    idle(3);
    check_all_zero();
    rstn = 1'b1;
    tick();

    // Directed cases
    pkt = '{8'h00, 8'h00};        run_pkt(0, mk(1, 0, 0, 0), 0, 0);
    pkt = '{8'h00, 8'h40, 8'hBF}; run_pkt(0, mk(1, 0, 0, 1), 0, 1);
    pkt = '{8'h00, 8'h41, 8'hBF}; run_pkt(0, mk(0, 0, 0, 1), 1, 0);
    pkt = '{8'h5A};               run_pkt(0, mk(0, 1, 0, 0), 0, 0);

    // Restart mid-packet: byte 11 leaves the buffer, no status for the aborted packet
    exp_out.push_back(8'h11);
    start_pkt();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    idle(1);
    pkt = '{8'h00, 8'h40, 8'hBF}; run_pkt(0, mk(1, 0, 0, 1), 0, 0);

    // Reset mid-packet
    exp_out.push_back(8'h11);
    exp_out.push_back(8'h22);
    start_pkt();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle(1);
    rstn = 1'b0;
    tick();
    check_all_zero();
    rstn = 1'b1;
    tick();
    pkt = '{8'h00, 8'h40, 8'hBF}; run_pkt(0, mk(1, 0, 0, 1), 0, 0);

    // Overflow: 6 payload bytes with valid CRC, end with last byte
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    c = model_crc(6);
    pkt.push_back(~c[7:0]);
    pkt.push_back(~c[15:8]);
    run_pkt(0, mk(1, 0, 1, 5), 1, 0);

    // Randomized packets
    for (int t = 0; t < 150; t++) begin
      pkt.delete();
      if ($urandom_range(0, 7) == 0) begin
        p = $urandom_range(0, 1);
        for (int i = 0; i < p; i++) pkt.push_back(8'($urandom));
      end else begin
        p = $urandom_range(0, 7);
        for (int i = 0; i < p; i++) pkt.push_back(8'($urandom));
        c = model_crc(p);
        pkt.push_back(~c[7:0]);
        pkt.push_back(~c[15:8]);
        if ($urandom_range(0, 2) == 0) begin
          idx = $urandom_range(0, pkt.size() - 1);
          pkt[idx] = pkt[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
      end
      run_pkt(1, mk(0, 0, 0, 0), $urandom_range(0, 1), 2);
    end

    idle(5);
    check("exp_out_drained", 32'(exp_out.size()), 32'd0);
    check("exp_st_drained",  32'(exp_st.size()),  32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
